// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit (SLL/SRA/ROR/SRL). The shift amount is resolved BPC bits per
// cycle, so latency is a fixed NSTEP cycles, with valid/ready handshakes on both sides.
module seq_shifter #(
  parameter  int WIDTH   = 16,
  parameter  int BPC     = 2,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   shift_in,
  input  logic [SHAMT_W-1:0] shift_val,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   shift_out,
  output logic               zero
);

  localparam int NSTEP  = (SHAMT_W + BPC - 1) / BPC;
  localparam int AMT_W  = NSTEP * BPC;
  localparam int STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] M_SLL = 2'd0;
  localparam logic [1:0] M_SRA = 2'd1;
  localparam logic [1:0] M_ROR = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [AMT_W-1:0]  amt_q, amt_d;
  logic [1:0]        mode_q, mode_d;
  logic              sign_q, sign_d;
  logic [WIDTH-1:0]  shift_out_q, shift_out_d;
  logic              zero_q, zero_d;

  logic [AMT_W-1:0]  s_amt;
  logic [WIDTH-1:0]  fill;
  logic [WIDTH-1:0]  stepped;

  // amt_q is consumed LSB-first; the padded top group reads as zeros.
  always_comb begin
    s_amt = AMT_W'(amt_q[BPC-1:0]) << (BPC * int'(step_q));
    case (mode_q)
      M_ROR:   fill = data_q;
      M_SRA:   fill = {WIDTH{sign_q}};
      default: fill = '0;
    endcase
    if (mode_q == M_SLL) stepped = data_q << s_amt;
    else                 stepped = WIDTH'({fill, data_q} >> s_amt);
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    data_d      = data_q;
    amt_d       = amt_q;
    mode_d      = mode_q;
    sign_d      = sign_q;
    shift_out_d = shift_out_q;
    zero_d      = zero_q;
    in_ready    = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = rst_n;
      ST_BUSY: begin
        data_d = stepped;
        amt_d  = amt_q >> BPC;
        step_d = step_q + STEP_W'(1);
        if (step_q == STEP_W'(NSTEP - 1)) begin
          state_d     = ST_DONE;
          step_d      = '0;
          shift_out_d = stepped;
          zero_d      = (stepped == '0);
        end
      end
      ST_DONE: begin
        in_ready = rst_n & out_ready;
        if (out_ready && !in_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (in_ready && in_valid) begin
      state_d = ST_BUSY;
      step_d  = '0;
      data_d  = shift_in;
      amt_d   = AMT_W'(shift_val);
      mode_d  = mode;
      sign_d  = shift_in[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      data_q      <= '0;
      amt_q       <= '0;
      mode_q      <= '0;
      sign_q      <= 1'b0;
      shift_out_q <= '0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      data_q      <= data_d;
      amt_q       <= amt_d;
      mode_q      <= mode_d;
      sign_q      <= sign_d;
      shift_out_q <= shift_out_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign shift_out = shift_out_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed and randomised checks of seq_shifter at 16b/BPC=2 and 32b/BPC=1.
module tb_seq_shifter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, zero;
  logic [15:0] shift_in, shift_out;
  logic [3:0]  shift_val;
  logic [1:0]  mode;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_zero;
  logic [31:0] b_shift_in, b_shift_out;
  logic [4:0]  b_shift_val;
  logic [1:0]  b_mode;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(16), .BPC(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .shift_in(shift_in), .shift_val(shift_val), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .shift_out(shift_out), .zero(zero));

  seq_shifter #(.WIDTH(32), .BPC(1)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .shift_in(b_shift_in), .shift_val(b_shift_val), .mode(b_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .shift_out(b_shift_out), .zero(b_zero));

  function automatic logic [15:0] ref16(input logic [15:0] d, input logic [3:0] a,
                                        input logic [1:0] m);
    logic [31:0] dd;
    logic [15:0] r;
    dd = {d, d} >> a;
    case (m)
      2'd0:    r = d << a;
      2'd1:    r = $signed(d) >>> a;
      2'd2:    r = dd[15:0];
      default: r = d >> a;
    endcase
    return r;
  endfunction

  // One full transaction; inputs are scrambled after acceptance to show they are not re-sampled.
  task automatic do_op(input bit w, input logic [31:0] d, input logic [4:0] a, input logic [1:0] m,
                       input int pre, input int post,
                       output logic [31:0] r, output logic z, output int lat);
    int t;
    repeat (pre) @(negedge clk);
    @(negedge clk);
    if (w) begin b_in_valid = 1; b_shift_in = d; b_shift_val = a; b_mode = m; end
    else begin in_valid = 1; shift_in = d[15:0]; shift_val = a[3:0]; mode = m; end
    t = 0;
    while (!(w ? b_in_ready : in_ready) && t < 50) begin @(negedge clk); t++; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; b_in_valid = 0;
    shift_in = ~shift_in; shift_val = ~shift_val; mode = ~mode;
    b_shift_in = ~b_shift_in; b_shift_val = ~b_shift_val; b_mode = ~b_mode;
    lat = 0;
    while (!(w ? b_out_valid : out_valid) && lat < 50) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    r = w ? b_shift_out : {16'h0, shift_out};
    z = w ? b_zero : zero;
    repeat (post) @(negedge clk);
    out_ready = 1; b_out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0; b_out_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 0; out_ready = 0; shift_in = '0; shift_val = '0; mode = '0;
    b_in_valid = 0; b_out_ready = 0; b_shift_in = '0; b_shift_val = '0; b_mode = '0;
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0 || shift_out !== 16'h0 || zero !== 1'b0) begin
      bad++; $display("FAIL rst_outs: got v=%b d=%h z=%b want 0/0000/0", out_valid, shift_out, zero); end
    rst_n = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_sra();
    logic [31:0] r; logic z; int lat;
    do_op(0, 32'hB84C, 5'd5, 2'd1, 0, 0, r, z, lat);
    total++; if (r[15:0] !== 16'hFDC2 || z !== 1'b0) begin bad++; $display("FAIL sra5: got %h z=%b want fdc2 z=0", r[15:0], z); end
    total++; if (lat !== 2) begin bad++; $display("FAIL sra5_lat: got %0d want 2", lat); end
    do_op(0, 32'hB84C, 5'd15, 2'd1, 0, 0, r, z, lat);
    total++; if (r[15:0] !== 16'hFFFF) begin bad++; $display("FAIL sra15: got %h want ffff", r[15:0]); end
    do_op(0, 32'h1B4C, 5'd15, 2'd1, 1, 2, r, z, lat);
    total++; if (r[15:0] !== 16'h0000 || z !== 1'b1) begin bad++; $display("FAIL sra15_pos: got %h z=%b want 0000 z=1", r[15:0], z); end
  endtask

  task automatic test_modes();
    logic [31:0] r; logic z; int lat;
    do_op(0, 32'hB84C, 5'd8, 2'd0, 0, 0, r, z, lat);
    total++; if (r[15:0] !== 16'h4C00) begin bad++; $display("FAIL sll8: got %h want 4c00", r[15:0]); end
    do_op(0, 32'hB84C, 5'd15, 2'd3, 0, 0, r, z, lat);
    total++; if (r[15:0] !== 16'h0001) begin bad++; $display("FAIL srl15: got %h want 0001", r[15:0]); end
    do_op(0, 32'hB84C, 5'd4, 2'd2, 0, 0, r, z, lat);
    total++; if (r[15:0] !== 16'hCB84) begin bad++; $display("FAIL ror4: got %h want cb84", r[15:0]); end
    do_op(0, 32'hB84C, 5'd0, 2'd2, 0, 0, r, z, lat);
    total++; if (r[15:0] !== 16'hB84C || lat !== 2) begin bad++; $display("FAIL ror0: got %h lat=%0d want b84c lat=2", r[15:0], lat); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    in_valid = 1; shift_in = 16'hB84C; shift_val = 4'd4; mode = 2'd3;
    @(posedge clk); @(negedge clk);
    in_valid = 0; shift_in = 16'h0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    total++; if (out_valid !== 1'b1 || shift_out !== 16'h0B84) begin
      bad++; $display("FAIL bp_first: got v=%b d=%h want 1/0b84", out_valid, shift_out); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      total++; if (out_valid !== 1'b1 || shift_out !== 16'h0B84 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d: got v=%b d=%h rdy=%b want 1/0b84/0", i, out_valid, shift_out, in_ready); end
    end
    out_ready = 1; in_valid = 1; shift_in = 16'h0001; shift_val = 4'd15; mode = 2'd0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_passthru: got %b want 1", in_ready); end
    @(posedge clk); @(negedge clk);
    out_ready = 0; in_valid = 0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL b2b_busy: got v=%b rdy=%b want 0/0", out_valid, in_ready); end
    repeat (2) begin @(posedge clk); @(negedge clk); end
    total++; if (out_valid !== 1'b1 || shift_out !== 16'h8000) begin
      bad++; $display("FAIL b2b_result: got v=%b d=%h want 1/8000", out_valid, shift_out); end
    out_ready = 1;
    @(posedge clk); @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_reset_midop();
    bit seen;
    @(negedge clk);
    in_valid = 1; shift_in = 16'h00FF; shift_val = 4'd9; mode = 2'd0;
    @(posedge clk); @(negedge clk);
    in_valid = 0;
    @(posedge clk); @(negedge clk);
    rst_n = 0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_rdy: got %b want 0", in_ready); end
    @(posedge clk); @(negedge clk);
    total++; if (out_valid !== 1'b0 || shift_out !== 16'h0 || zero !== 1'b0) begin
      bad++; $display("FAIL midrst_outs: got v=%b d=%h z=%b want 0/0000/0", out_valid, shift_out, zero); end
    rst_n = 1;
    seen = 0;
    repeat (6) begin @(posedge clk); @(negedge clk); if (out_valid) seen = 1; end
    total++; if (seen !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_no_result: got seen=%b rdy=%b want 0/1", seen, in_ready); end
  endtask

  task automatic test_wide();
    logic [31:0] r; logic z; int lat;
    do_op(1, 32'h80000000, 5'd31, 2'd1, 0, 0, r, z, lat);
    total++; if (r !== 32'hFFFFFFFF || lat !== 5) begin bad++; $display("FAIL w_sra31: got %h lat=%0d want ffffffff lat=5", r, lat); end
    do_op(1, 32'h00000001, 5'd1, 2'd2, 0, 0, r, z, lat);
    total++; if (r !== 32'h80000000) begin bad++; $display("FAIL w_ror1: got %h want 80000000", r); end
  endtask

  task automatic test_random();
    logic [31:0] r; logic z; int lat;
    logic [15:0] d, exp;
    logic [3:0]  a;
    logic [1:0]  m;
    for (int i = 0; i < 30; i++) begin
      d = 16'($urandom); a = 4'($urandom); m = 2'($urandom);
      if (i % 7 == 0) d = 16'h0;
      exp = ref16(d, a, m);
      do_op(0, {16'h0, d}, {1'b0, a}, m, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), r, z, lat);
      total++; if (r[15:0] !== exp || z !== (exp == 16'h0)) begin
        bad++; $display("FAIL rnd%0d: d=%h a=%0d m=%0d got %h z=%b want %h", i, d, a, m, r[15:0], z, exp); end
      total++; if (lat !== 2) begin bad++; $display("FAIL rnd%0d_lat: got %0d want 2", i, lat); end
    end
  endtask

  initial begin
    test_reset();
    test_sra();
    test_modes();
    test_backpressure();
    test_reset_midop();
    test_wide();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
